// File: rtl/unpack_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unpack_stream_arbiter
// Description : Packet-granular round-robin arbiter feeding a single
//               32-bit-to-7-bit unpacker input port from NUM_REQ word
//               streams. Out-of-packet words are discarded and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module unpack_stream_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 32,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int DROP_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_sop,
    input  logic [NUM_REQ-1:0]           req_eop,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         unp_ready,
    output logic                         unp_valid,
    output logic [DATA_SIZE-1:0]         unp_data,
    output logic                         unp_sop,
    output logic                         unp_eop,
    output logic [ID_W-1:0]              grant_id,
    output logic                         grant_active,
    output logic [DROP_W-1:0]            drop_count,
    output logic                         protocol_err
);

    localparam logic [1:0]      c_ST_IDLE   = 2'd0;
    localparam logic [1:0]      c_ST_OFFER  = 2'd1;
    localparam logic [1:0]      c_ST_LOCKED = 2'd2;
    localparam int              c_CNT_W     = $clog2(NUM_REQ + 1);
    localparam int              c_SUM_W     = DROP_W + 1;
    localparam logic [ID_W-1:0] c_LAST_ID   = ID_W'(NUM_REQ - 1);

    logic [1:0]          r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_lock_id;
    logic [ID_W-1:0]     r_grant_id;
    logic [DROP_W-1:0]   r_drop_count;

    logic [1:0]          w_next_state;
    logic [ID_W-1:0]     w_next_rr;
    logic [ID_W-1:0]     w_next_lock;
    logic                w_live;
    logic [NUM_REQ-1:0]  w_cand;
    logic                w_win_found;
    logic [ID_W-1:0]     w_win_id;
    logic                w_granted;
    logic [ID_W-1:0]     w_gid;
    logic                w_acc;
    logic [NUM_REQ-1:0]  w_drop;
    logic [c_CNT_W-1:0]  w_drop_num;
    logic [c_SUM_W-1:0]  w_drop_sum;
    logic [DATA_SIZE-1:0] w_data_arr [NUM_REQ];

    function automatic logic [ID_W-1:0] f_next_id(input logic [ID_W-1:0] id);
        return (id == c_LAST_ID) ? '0 : id + ID_W'(1);
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_data_arr[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
    end

    // Nothing is consumed or offered while reset is held.
    assign w_live = ~rst;
    assign w_cand = req_valid & req_sop;

    // Round-robin search: first sop candidate at or above rr_ptr, wrapping.
    always_comb begin
        int ix;
        ix          = 0;
        w_win_found = 1'b0;
        w_win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ix = int'(r_rr_ptr) + k;
            if (ix >= NUM_REQ) ix = ix - NUM_REQ;
            if (!w_win_found && w_cand[ix]) begin
                w_win_found = 1'b1;
                w_win_id    = ID_W'(ix);
            end
        end
    end

    // Select the requester being served: fresh winner in IDLE, else the lock.
    always_comb begin
        w_granted = 1'b0;
        w_gid     = r_lock_id;
        case (r_state)
            c_ST_IDLE: begin
                w_granted = w_live & w_win_found;
                w_gid     = w_win_id;
            end
            c_ST_OFFER, c_ST_LOCKED: begin
                w_granted = w_live;
                w_gid     = r_lock_id;
            end
            default: w_granted = 1'b0;
        endcase
    end

    assign unp_valid    = w_granted & req_valid[w_gid];
    assign unp_data     = w_data_arr[w_gid];
    assign unp_sop      = unp_valid & req_sop[w_gid];
    assign unp_eop      = unp_valid & req_eop[w_gid];
    assign w_acc        = unp_valid & unp_ready;
    assign grant_active = w_granted;
    assign grant_id     = rst ? '0 : (w_granted ? w_gid : r_grant_id);
    assign drop_count   = r_drop_count;
    // A sop accepted mid-packet is still forwarded; only flagged.
    assign protocol_err = (r_state == c_ST_LOCKED) & w_acc & req_sop[r_lock_id];

    // Per-requester ready: granted one follows the unpacker, stray words are dropped.
    always_comb begin
        logic is_g;
        is_g       = 1'b0;
        w_drop     = '0;
        req_ready  = '0;
        w_drop_num = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            is_g         = w_granted && (ID_W'(i) == w_gid);
            w_drop[i]    = w_live & req_valid[i] & ~req_sop[i] & ~is_g;
            req_ready[i] = is_g ? unp_ready : w_drop[i];
            w_drop_num   = w_drop_num + c_CNT_W'(w_drop[i]);
        end
    end

    assign w_drop_sum = {1'b0, r_drop_count} + c_SUM_W'(w_drop_num);

    // Packet framing FSM: IDLE arbitrates, OFFER waits for the sop accept,
    // LOCKED streams until the eop accept.
    always_comb begin
        w_next_state = r_state;
        w_next_rr    = r_rr_ptr;
        w_next_lock  = r_lock_id;
        case (r_state)
            c_ST_IDLE: begin
                if (w_win_found) begin
                    w_next_lock = w_win_id;
                    if (!unp_ready) begin
                        w_next_state = c_ST_OFFER;
                    end else if (req_eop[w_win_id]) begin
                        w_next_rr = f_next_id(w_win_id);
                    end else begin
                        w_next_state = c_ST_LOCKED;
                    end
                end
            end
            c_ST_OFFER: begin
                if (w_acc) begin
                    if (unp_eop) begin
                        w_next_state = c_ST_IDLE;
                        w_next_rr    = f_next_id(r_lock_id);
                    end else begin
                        w_next_state = c_ST_LOCKED;
                    end
                end
            end
            c_ST_LOCKED: begin
                if (w_acc && unp_eop) begin
                    w_next_state = c_ST_IDLE;
                    w_next_rr    = f_next_id(r_lock_id);
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // State, pointers, last grant and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_rr_ptr     <= '0;
            r_lock_id    <= '0;
            r_grant_id   <= '0;
            r_drop_count <= '0;
        end else begin
            r_state   <= w_next_state;
            r_rr_ptr  <= w_next_rr;
            r_lock_id <= w_next_lock;
            if (w_granted) r_grant_id <= w_gid;
            r_drop_count <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
        end
    end

endmodule
`default_nettype wire
